// File: rtl/pkt_store_fwd_fifo.sv
`default_nettype none
// ============================================================================
// pkt_store_fwd_fifo : store-and-forward AXI4-Stream packet FIFO; releases a
// packet only once its tlast beat is written, drops packets that do not fit.
// Revision 1.0
// ============================================================================
module pkt_store_fwd_fifo #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    input  logic [DATA_WIDTH-1:0]    in_tdata,
    input  logic                     in_tlast,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [DATA_WIDTH-1:0]    out_tdata,
    output logic                     out_tlast,
    output logic [COUNT_WIDTH-1:0]   pkt_count,
    output logic [COUNT_WIDTH-1:0]   drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    logic [DATA_WIDTH:0]    mem_q [DEPTH];
    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_spec_q, wr_spec_d;
    logic [PW-1:0]          wr_cmt_q, wr_cmt_d;
    logic [PW-1:0]          rd_q, rd_d;
    logic [COUNT_WIDTH-1:0] pkt_q, pkt_d;
    logic [COUNT_WIDTH-1:0] drop_q, drop_d;
    logic                   rdy_q;
    logic                   ovld_q, ovld_d;
    logic [DATA_WIDTH:0]    odata_q, odata_d;
    logic                   w_beat;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_rd_en;

    assign w_beat = in_tvalid && rdy_q;
    // Full is judged on registered pointers only; a same-cycle read frees nothing.
    assign w_full = ((wr_spec_q - rd_q) == C_DEPTH);

    always_comb begin
        state_d   = state_q;
        wr_spec_d = wr_spec_q;
        wr_cmt_d  = wr_cmt_q;
        pkt_d     = pkt_q;
        drop_d    = drop_q;
        w_wr_en   = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (w_beat) begin
                    if (!w_full) begin
                        w_wr_en   = 1'b1;
                        wr_spec_d = wr_spec_q + PW'(1);
                        if (in_tlast) begin
                            wr_cmt_d = wr_spec_q + PW'(1);
                            pkt_d    = (pkt_q == '1) ? pkt_q : pkt_q + COUNT_WIDTH'(1);
                        end
                    end else begin
                        wr_spec_d = wr_cmt_q;
                        drop_d    = (drop_q == '1) ? drop_q : drop_q + COUNT_WIDTH'(1);
                        if (!in_tlast) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (w_beat && in_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Single output register stage; only committed slots are ever read.
    always_comb begin
        rd_d    = rd_q;
        ovld_d  = ovld_q;
        odata_d = odata_q;
        w_rd_en = (rd_q != wr_cmt_q) && (!ovld_q || out_tready);
        if (w_rd_en) begin
            ovld_d  = 1'b1;
            odata_d = mem_q[rd_q[AW-1:0]];
            rd_d    = rd_q + PW'(1);
        end else if (out_tready) begin
            ovld_d  = 1'b0;
            odata_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            mem_q[wr_spec_q[AW-1:0]] <= {in_tlast, in_tdata};
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_ACCEPT;
            wr_spec_q <= '0;
            wr_cmt_q  <= '0;
            rd_q      <= '0;
            pkt_q     <= '0;
            drop_q    <= '0;
            rdy_q     <= 1'b0;
            ovld_q    <= 1'b0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_spec_q <= wr_spec_d;
            wr_cmt_q  <= wr_cmt_d;
            rd_q      <= rd_d;
            pkt_q     <= pkt_d;
            drop_q    <= drop_d;
            rdy_q     <= 1'b1;
            ovld_q    <= ovld_d;
            odata_q   <= odata_d;
        end
    end

    assign in_tready  = rdy_q;
    assign out_tvalid = ovld_q;
    assign out_tdata  = odata_q[DATA_WIDTH-1:0];
    assign out_tlast  = odata_q[DATA_WIDTH];
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign level      = wr_spec_q - rd_q;

endmodule
`default_nettype wire
